pattern_sweep_ctrl: RTL and testbench
=====================================

Name: pattern_sweep_ctrl

Overview:
Hardware sequencer for exhaustive stimulus sweeps of a combinational/sequential benchmark DUT.
- Steps a pattern counter through all 2^N_WIDTH input vectors and drives each onto the DUT.
- Waits a programmable settle time, then samples the DUT response.
- Emits one (pattern, response) record per vector over a valid/ready handshake to a capture sink.
- Sits between the test-control logic (start/abort) and the DUT-plus-logger pair. It replaces the fixed-delay software stepping loop with a cycle-exact, back-pressurable schedule.

Parameters:
N_WIDTH, 4, width of the DUT input vector; sweep covers 0 .. 2^N_WIDTH-1.
OUT_WIDTH, 1, width of the DUT response.
SETTLE, 1, cycles a pattern is held before sampling; legal range 1..255.

Ports:
CK  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-low reset; 0 forces reset immediately.
start  input  1  begin sweep; sampled only in IDLE.
abort  input  1  terminate sweep from any state.
pat_out  output  N_WIDTH  stimulus vector to DUT (registered).
dut_resp  input  OUT_WIDTH  DUT output.
rec_valid  output  1  record available.
rec_ready  input  1  sink accepts record.
rec_pat  output  N_WIDTH  pattern of current record.
rec_resp  output  OUT_WIDTH  sampled response of current record.
busy  output  1  high in WAIT/EMIT.
done  output  1  one-cycle pulse when the sweep completes normally.
sig_out  output  16  MISR signature (only with SWEEP_MISR_EN).

Behaviour:
- Reset (reset=0, async): state=IDLE. pat_out, rec_pat, rec_resp, rec_valid, busy and done are 0; sig_out=16'hFFFF.
- States: IDLE, WAIT, EMIT, DONE.
- IDLE -> WAIT when start=1 and abort=0.
  - On entry, pat_out=0 and the settle counter is loaded with SETTLE.
- WAIT: pat_out is held and the counter decrements each cycle.
  - On the SETTLE-th WAIT cycle edge: rec_resp<=dut_resp, rec_pat<=pat_out, rec_valid<=1, go to EMIT.
- EMIT: rec_valid, rec_pat, rec_resp and pat_out are held stable until rec_valid&&rec_ready (handshake).
  - On handshake, if pat_out != all-ones: pat_out<=pat_out+1, reload the counter, rec_valid<=0, go to WAIT.
  - On handshake, if pat_out == all-ones: rec_valid<=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. pat_out returns to 0 in IDLE.
- Latency: with start seen at edge t0 and rec_ready tied high:
  - first rec_valid visible after edge t0+1+SETTLE;
  - one record every SETTLE+1 cycles;
  - DONE state occupies the cycle after edge t0+1+2^N_WIDTH*(SETTLE+1).
- Increment is modulo 2^N_WIDTH. No wrap ever occurs because the sweep ends at all-ones.
- abort=1 in any non-IDLE state: next edge goes to IDLE, rec_valid=0, done not pulsed, pat_out=0.
  - abort has priority over a simultaneous handshake or start.
- start while not IDLE: ignored. start held high through DONE re-arms a new sweep from IDLE on the following edge.
- rec_ready while rec_valid=0: ignored.
- busy=1 exactly in WAIT and EMIT.

Optional Feature:
Macro SWEEP_MISR_EN.
- Defined: a 16-bit Fibonacci MISR (taps 16,14,13,11) compacts responses.
  - Seeded to 16'hFFFF on the IDLE->WAIT transition.
  - On each handshake: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {{(16-OUT_WIDTH){1'b0}}, rec_resp}.
  - sig_out is stable from DONE until the next start.
- Not defined: port sig_out and all MISR logic are absent. Record and handshake timing are identical in both builds.

Test Plan:
- N_WIDTH=4, SETTLE=1, rec_ready=1, dut_resp=pat_out[0]: 16 records with rec_pat 0..15 and rec_resp alternating 0,1. done pulses once, in the cycle after edge t0+33.
- rec_ready low for 5 cycles while rec_pat=3: rec_valid stays 1; rec_pat=3, rec_resp and pat_out=3 stay unchanged; the next record is pat 4; still 16 records total.
- SETTLE=3, DUT response a 2-cycle registered copy of pat_out: every rec_resp equals its rec_pat[0] (no stale samples); 4 cycles per record.
- abort asserted in EMIT at rec_pat=7, same cycle as rec_ready=1: next cycle state IDLE, rec_valid=0, pat_out=0, busy=0, no done pulse; the record is counted as not delivered.
- reset driven low mid-sweep (pat 10, WAIT): outputs go to 0 asynchronously without a clock edge. After release, start produces a fresh sweep from pat 0.
- SWEEP_MISR_EN build, dut_resp=pat_out[3]: sig_out after done matches the software MISR model over responses 0×8 then 1×8. A second identical sweep gives the same sig_out; start pulsed during a sweep has no effect.

Source files
------------

// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive pattern sweep sequencer: drives 0..2^N_WIDTH-1, waits a settle time,
// emits (pattern, response) records over valid/ready. Optional MISR: SWEEP_MISR_EN.
module pattern_sweep_ctrl #(
  parameter int N_WIDTH   = 4,
  parameter int OUT_WIDTH = 1,
  parameter int SETTLE    = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_WIDTH-1:0]   pat_out,
  input  logic [OUT_WIDTH-1:0] dut_resp,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_pat,
  output logic [OUT_WIDTH-1:0] rec_resp,
  output logic                 busy,
  output logic                 done
`ifdef SWEEP_MISR_EN
  ,
  output logic [15:0]          sig_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The first pattern gets one extra settle cycle relative to later patterns,
  // which keeps the first-record latency at SETTLE+1 and the period at SETTLE+1.
  localparam logic [7:0]           CNT_FIRST = 8'(SETTLE);
  localparam logic [7:0]           CNT_NEXT  = 8'(SETTLE - 1);
  localparam logic [N_WIDTH-1:0]   PAT_ZERO  = {N_WIDTH{1'b0}};
  localparam logic [N_WIDTH-1:0]   PAT_ONE   = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0]   PAT_LAST  = {N_WIDTH{1'b1}};

  state_t               r_state;
  logic [N_WIDTH-1:0]   r_pat;
  logic [7:0]           r_cnt;
  logic [N_WIDTH-1:0]   r_rec_pat;
  logic [OUT_WIDTH-1:0] r_rec_resp;
  logic                 r_rec_valid;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [N_WIDTH-1:0]   w_pat_nxt;
  logic [7:0]           w_cnt_nxt;
  logic [N_WIDTH-1:0]   w_rec_pat_nxt;
  logic [OUT_WIDTH-1:0] w_rec_resp_nxt;
  logic                 w_rec_valid_nxt;
  logic                 w_hs;

  assign w_hs = r_rec_valid & rec_ready;

  // Next-state and next-datapath decode; abort from any active state wins.
  always_comb begin
    w_state_nxt     = r_state;
    w_pat_nxt       = r_pat;
    w_cnt_nxt       = r_cnt;
    w_rec_pat_nxt   = r_rec_pat;
    w_rec_resp_nxt  = r_rec_resp;
    w_rec_valid_nxt = r_rec_valid;
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt     = S_IDLE;
      w_pat_nxt       = PAT_ZERO;
      w_rec_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_pat_nxt       = PAT_ZERO;
          w_rec_valid_nxt = 1'b0;
          if (start && !abort) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_FIRST;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            w_state_nxt     = S_EMIT;
            w_rec_pat_nxt   = r_pat;
            w_rec_resp_nxt  = dut_resp;
            w_rec_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            w_rec_valid_nxt = 1'b0;
            if (r_pat == PAT_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_WAIT;
              w_pat_nxt   = r_pat + PAT_ONE;
              w_cnt_nxt   = CNT_NEXT;
            end
          end else begin
            w_state_nxt = S_EMIT;
          end
        end
        S_DONE: begin
          w_state_nxt     = S_IDLE;
          w_pat_nxt       = PAT_ZERO;
          w_rec_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_pat_nxt       = PAT_ZERO;
          w_rec_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and flag registers; every output is taken from these.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pat       <= PAT_ZERO;
      r_cnt       <= 8'd0;
      r_rec_pat   <= PAT_ZERO;
      r_rec_resp  <= {OUT_WIDTH{1'b0}};
      r_rec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pat       <= w_pat_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rec_pat   <= w_rec_pat_nxt;
      r_rec_resp  <= w_rec_resp_nxt;
      r_rec_valid <= w_rec_valid_nxt;
      r_busy      <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_EMIT);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign pat_out   = r_pat;
  assign rec_valid = r_rec_valid;
  assign rec_pat   = r_rec_pat;
  assign rec_resp  = r_rec_resp;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef SWEEP_MISR_EN
  logic [15:0] r_sig;
  logic [15:0] w_sig_nxt;
  logic        w_seed;
  logic        w_step;

  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [OUT_WIDTH-1:0] resp);
    misr_step = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^
                {{(16-OUT_WIDTH){1'b0}}, resp};
  endfunction

  assign w_seed = (r_state == S_IDLE) && start && !abort;
  assign w_step = (r_state == S_EMIT) && w_hs && !abort;

  // Signature update: seeded at sweep start, folded once per delivered record.
  always_comb begin
    w_sig_nxt = r_sig;
    if (w_seed) begin
      w_sig_nxt = 16'hFFFF;
    end else if (w_step) begin
      w_sig_nxt = misr_step(r_sig, r_rec_resp);
    end else begin
      w_sig_nxt = r_sig;
    end
  end

  // Signature register.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_sig <= 16'hFFFF;
    end else begin
      r_sig <= w_sig_nxt;
    end
  end

  assign sig_out = r_sig;
`endif

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Scoreboard bench for pattern_sweep_ctrl: random response tables, backpressure,
// abort, mid-sweep reset, start re-arm; MISR checked when SWEEP_MISR_EN is defined.
module tb_pattern_sweep_ctrl;
  localparam int N    = 4;
  localparam int OW   = 1;
  localparam int ST   = 3;
  localparam int NPAT = 16;

  logic          CK = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rec_ready = 1'b0;
  logic [N-1:0]  pat_out, rec_pat;
  logic [OW-1:0] dut_resp, rec_resp;
  logic          rec_valid, busy, done;
`ifdef SWEEP_MISR_EN
  logic [15:0]   sig_out;
`endif

  typedef struct {
    logic [N-1:0]  p;
    logic [OW-1:0] r;
  } rec_t;

  rec_t          exp_q[$];
  logic [OW-1:0] tab [NPAT];
  logic [N-1:0]  d1, d2;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_hs = 0, n_done = 0, last_hs = -1;
  bit timing_chk = 1'b0;
  bit held = 1'b0;
  logic [N-1:0]  held_pat;
  logic [OW-1:0] held_resp;

  pattern_sweep_ctrl #(.N_WIDTH(N), .OUT_WIDTH(OW), .SETTLE(ST)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .pat_out(pat_out),
    .dut_resp(dut_resp), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pat(rec_pat), .rec_resp(rec_resp), .busy(busy), .done(done)
`ifdef SWEEP_MISR_EN
    , .sig_out(sig_out)
`endif
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Benchmark DUT: a lookup table behind a two-stage register on pat_out.
  always @(posedge CK or negedge reset) begin
    if (!reset) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= pat_out;
      d2 <= d1;
    end
  end
  assign dut_resp = tab[d2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pop on each delivered record, verify hold-stability under backpressure.
  always @(negedge CK) begin
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(rec_valid), 32'd1);
        check("hold_pat", 32'(rec_pat), 32'(held_pat));
        check("hold_resp", 32'(rec_resp), 32'(held_resp));
        check("hold_pat_out", 32'(pat_out), 32'(held_pat));
      end
      if (rec_valid) check("busy_in_emit", 32'(busy), 32'd1);
      if (rec_valid && rec_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 32'(rec_pat), 32'hFFFF_FFFF);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          check("rec_pat", 32'(rec_pat), 32'(e.p));
          check("rec_resp", 32'(rec_resp), 32'(e.r));
        end
        if (timing_chk && last_hs >= 0) check("rec_interval", 32'(cyc - last_hs), 32'(ST + 1));
        last_hs = cyc;
        n_hs++;
      end
      if (done) n_done++;
      held = rec_valid && !rec_ready && !abort;
      held_pat = rec_pat;
      held_resp = rec_resp;
    end
  end

  task automatic new_table();
    for (int i = 0; i < NPAT; i++) tab[i] = OW'($urandom_range(0, (1 << OW) - 1));
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NPAT; i++) begin
      rec_t e;
      e.p = N'(i);
      e.r = tab[i];
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [15:0] misr_model();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < NPAT; i++) begin
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      s = ((s << 1) | 16'(fb)) ^ 16'(tab[i]);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Run until done with random or full readiness; optional one-cycle start pulse mid-sweep.
  task automatic run_to_done(input bit rand_ready, input int start_pulse_at, output bit ok);
    int stall;
    stall = 0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = (k == start_pulse_at);
      if (rand_ready && rec_valid && rec_pat == N'(3) && stall < 5) begin
        rec_ready = 1'b0;
        stall++;
      end else begin
        rec_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    start = 1'b0;
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int c0, first_v, done_c, hs0, dn0;
    void'($urandom(32'h5eed));
    new_table();
    // Reset state.
    #23;
    check("rst_pat_out", 32'(pat_out), 32'd0);
    check("rst_rec_valid", 32'(rec_valid), 32'd0);
    check("rst_rec_pat", 32'(rec_pat), 32'd0);
    check("rst_rec_resp", 32'(rec_resp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef SWEEP_MISR_EN
    check("rst_sig", 32'(sig_out), 32'hFFFF);
`endif
    tick();
    reset = 1'b1;
    tick();

    // start together with abort in IDLE must not launch.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("start_abort_idle_busy", 32'(busy), 32'd0);

    // Sweep A: ready tied high, cycle-exact latency.
    push_sweep();
    rec_ready = 1'b1;
    timing_chk = 1'b1; last_hs = -1;
    hs0 = n_hs; dn0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc; first_v = -1; done_c = -1;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < 200; k++) begin
      if (rec_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_c = cyc;
        break;
      end
      tick();
    end
    timing_chk = 1'b0;
    check("first_valid_cycle", 32'(first_v - c0), 32'(1 + ST));
    check("done_cycle", 32'(done_c - c0), 32'(1 + NPAT * (ST + 1)));
    check("busy_in_done", 32'(busy), 32'd0);
`ifdef SWEEP_MISR_EN
    check("sig_sweep_a", 32'(sig_out), 32'(misr_model()));
`endif
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("pat_out_idle", 32'(pat_out), 32'd0);
    check("records_a", 32'(n_hs - hs0), 32'(NPAT));
    check("dones_a", 32'(n_done - dn0), 32'd1);

    // Sweep B: same table, random backpressure with a 5-cycle stall at pat 3, stray start.
    push_sweep();
    hs0 = n_hs; dn0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1'b1, 20, ok);
`ifdef SWEEP_MISR_EN
    check("sig_sweep_b", 32'(sig_out), 32'(misr_model()));
`endif
    tick();
    check("records_b", 32'(n_hs - hs0), 32'(NPAT));
    check("dones_b", 32'(n_done - dn0), 32'd1);
    check("queue_empty_b", 32'(exp_q.size()), 32'd0);

    // Sweep C: abort in EMIT at pat 7 together with rec_ready.
    new_table();
    push_sweep();
    hs0 = n_hs; dn0 = n_done;
    rec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (rec_valid && rec_pat == N'(7)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("abort_wait_timeout", 32'd0, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(rec_valid), 32'd0);
    check("abort_pat_out", 32'(pat_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (8) tick();
    check("abort_no_done", 32'(n_done - dn0), 32'd0);
    check("records_c", 32'(n_hs - hs0), 32'd7);
    exp_q.delete();

    // Sweep D: asynchronous reset in WAIT at pat 10, then a fresh sweep.
    push_sweep();
    hs0 = n_hs;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (pat_out == N'(10) && !rec_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("reset_wait_timeout", 32'd0, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pat_out", 32'(pat_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rec_pat", 32'(rec_pat), 32'd0);
    check("records_d", 32'(n_hs - hs0), 32'd10);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    new_table();
    push_sweep();
    hs0 = n_hs; dn0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1'b1, -1, ok);
    tick();
    check("records_after_reset", 32'(n_hs - hs0), 32'(NPAT));
    check("dones_after_reset", 32'(n_done - dn0), 32'd1);

    // Sweep E: start held high through DONE re-arms a second identical sweep.
    push_sweep();
    push_sweep();
    hs0 = n_hs; dn0 = n_done;
    rec_ready = 1'b1;
    start = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rearm_first_timeout", 32'd0, 32'd1);
    tick();
    check("rearm_idle_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("rearm_busy", 32'(busy), 32'd1);
    run_to_done(1'b0, -1, ok);
`ifdef SWEEP_MISR_EN
    check("sig_rearm", 32'(sig_out), 32'(misr_model()));
`endif
    tick();
    check("records_e", 32'(n_hs - hs0), 32'(2 * NPAT));
    check("dones_e", 32'(n_done - dn0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
